lane_masked_memory: RTL
=======================

Name: lane_masked_memory

Overview:
- Parametrised single-port synchronous memory; next generation of the team's simple enable/readWrite memory.
- Adds a clocked valid/ready request interface, per-lane write masks, a fixed and configurable read latency, and a hardware clear sequencer that zero-fills the array.
- Sits between a processor/datapath master and local storage; one request per cycle, responses in order.

Parameters:
- wordSize, 8, data width in bits; must be a multiple of laneSize.
- laneSize, 4, bits per maskable lane; numLanes = wordSize/laneSize.
- numWords, 64, depth in words; need not be a power of two.
- readLatency, 1, cycles from read acceptance to rspValid; legal values 1 or 2.

Ports:
- clk  input  1  rising-edge clock.
- rstN  input  1  asynchronous active-low reset.
- clear  input  1  synchronous request to zero-fill the whole array.
- reqValid  input  1  request present.
- reqReady  output  1  block can accept a request this cycle.
- reqWrite  input  1  1 = write, 0 = read.
- reqAddr  input  $clog2(numWords)  word address.
- reqData  input  wordSize  write data.
- reqMask  input  numLanes  per-lane write enable; bit i covers data bits [i*laneSize +: laneSize].
- rspValid  output  1  read data valid, one-cycle pulse per read.
- rspData  output  wordSize  read data.
- initDone  output  1  high while the array is initialised and requests are accepted.

Behaviour:
- Reset (rstN low, asynchronous): state = INIT, sweep counter = 0, reqReady = 0, initDone = 0, rspValid = 0, rspData = 0; all in-flight reads dropped. Array contents are not reset directly; the INIT sweep zeroes them.
- FSM states: INIT, IDLE.
- INIT: writes zero to address counter value each cycle, counter increments 0..numWords-1; after writing numWords-1, next state = IDLE. Takes exactly numWords cycles after rstN deasserts. reqReady = 0, initDone = 0.
- IDLE: reqReady = 1, initDone = 1. clear = 1 in IDLE -> INIT with counter = 0 next cycle; a request presented in that same cycle is still accepted (clear takes effect next cycle).
- clear = 1 during INIT restarts the counter at 0.
- Acceptance = reqValid && reqReady. No request is accepted in INIT; reqValid is ignored there with no side effects.
- Write: at the accepting edge, every lane whose mask bit is 1 takes reqData; lanes with mask 0 keep their value. mask = 0 is a legal no-op. No response is generated.
- Read: array is sampled at the accepting edge. rspValid = 1 exactly readLatency cycles after acceptance, for one cycle. With readLatency = 2 the data passes through one extra register stage. Back-to-back reads give back-to-back pulses in order.
- rspData holds its last value when rspValid = 0 (never Z, never cleared except by reset).
- No response backpressure; the master must always accept rspValid.
- Read-after-write: a write accepted in cycle N followed by a read of the same address accepted in N+1 returns the new data.
- Reads already accepted when clear or INIT begins complete normally, carrying the pre-clear data.
- Out-of-range address (reqAddr >= numWords): write ignored; read responds normally with rspData = 0.

Test Plan:
- Reset then release, numWords=64 -> reqReady/initDone rise exactly 64 cycles after rstN high; reads of addresses 0, 31 and 63 return 0x00.
- Write addr 5 data 0xA5 mask 2'b11, then write addr 5 data 0x3C mask 2'b01, read addr 5 -> rspData = 0xAC.
- readLatency=2: reads of addr 1, 2, 3 on consecutive cycles (data 0x11, 0x22, 0x33) -> rspValid high on cycles +2, +3, +4 with 0x11, 0x22, 0x33 in order.
- Write addr 9 = 0x7E in cycle N, read addr 9 in cycle N+1 -> rspData = 0x7E at N+1+readLatency.
- Read addr 4 (=0x44) accepted in the same cycle as clear -> response 0x44 still delivered; reqReady low for 64 cycles; a later read of addr 4 returns 0x00.
- numWords=48: write addr 50 = 0xFF, read addr 50 -> rspValid pulse with rspData = 0x00, other contents unchanged. Assert rstN low mid-read -> rspValid = 0 immediately and no pulse after release.

Source files
------------

// File: rtl/lane_masked_memory.sv
// lane_masked_memory
//   Single-port synchronous word memory with a valid/ready request port,
//   per-lane write masks, a fixed read latency of 1 or 2 cycles and a
//   hardware sweep that zero-fills the array after reset or on clear.
//
// Ports
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset
//   clear     request to zero-fill the array (takes effect next cycle)
//   reqValid  request present
//   reqReady  request can be accepted this cycle (IDLE only)
//   reqWrite  1 = write, 0 = read
//   reqAddr   word address; addresses >= numWords are out of range
//   reqData   write data
//   reqMask   per-lane write enable, bit i covers [i*laneSize +: laneSize]
//   rspValid  one-cycle pulse per read, readLatency cycles after acceptance
//   rspData   read data; holds its last value between pulses
//   initDone  array initialised and requests are accepted
module lane_masked_memory #(
   parameter int wordSize    = 8,
   parameter int laneSize    = 4,
   parameter int numWords    = 64,
   parameter int readLatency = 1
) (
   input  logic                            clk,
   input  logic                            rstN,
   input  logic                            clear,
   input  logic                            reqValid,
   output logic                            reqReady,
   input  logic                            reqWrite,
   input  logic [$clog2(numWords)-1:0]     reqAddr,
   input  logic [wordSize-1:0]             reqData,
   input  logic [wordSize/laneSize-1:0]    reqMask,
   output logic                            rspValid,
   output logic [wordSize-1:0]             rspData,
   output logic                            initDone
);

   localparam int ADDR_W    = $clog2(numWords);
   localparam int NUM_LANES = wordSize / laneSize;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(numWords - 1);

   typedef enum logic {INIT, IDLE} state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   sweep_cnt, sweep_cnt_next;
   logic                accept, wr_accept, rd_accept, addr_in_range;
   logic [wordSize-1:0] mem [numWords];

   logic                vld_p0;
   logic [wordSize-1:0] rd_data_p0;

   // Replace only the lanes whose mask bit is set.
   function automatic logic [wordSize-1:0] merge_lanes(
      input logic [wordSize-1:0]  old_word,
      input logic [wordSize-1:0]  new_word,
      input logic [NUM_LANES-1:0] lane_mask
   );
      logic [wordSize-1:0] result;
      result = old_word;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_mask[i]) begin
            result[i*laneSize +: laneSize] = new_word[i*laneSize +: laneSize];
         end
      end
      return result;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= INIT;
         sweep_cnt <= '0;
      end else begin
         state     <= state_next;
         sweep_cnt <= sweep_cnt_next;
      end
   end

   // Next-state logic. clear during the sweep restarts it from address 0.
   always_comb begin
      state_next     = state;
      sweep_cnt_next = sweep_cnt;
      case (state)
         INIT: begin
            if (clear) begin
               sweep_cnt_next = '0;
            end else if (sweep_cnt == LAST_ADDR) begin
               state_next     = IDLE;
               sweep_cnt_next = '0;
            end else begin
               sweep_cnt_next = sweep_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (clear) begin
               state_next     = INIT;
               sweep_cnt_next = '0;
            end
         end
         default: begin
            state_next     = INIT;
            sweep_cnt_next = '0;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      reqReady = (state == IDLE);
      initDone = (state == IDLE);
   end

   assign accept        = reqValid && reqReady;
   assign wr_accept     = accept && reqWrite;
   assign rd_accept     = accept && !reqWrite;
   assign addr_in_range = ({1'b0, reqAddr} < (ADDR_W + 1)'(numWords));

   // Storage: the sweep owns the port during INIT, so no request can collide.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[sweep_cnt] <= '0;
      end else if (wr_accept && addr_in_range) begin
         mem[reqAddr] <= merge_lanes(mem[reqAddr], reqData, reqMask);
      end
   end

   // Stage p0: array sampled at the accepting edge; out-of-range reads give 0.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         vld_p0     <= 1'b0;
         rd_data_p0 <= '0;
      end else begin
         vld_p0 <= rd_accept;
         if (rd_accept) begin
            rd_data_p0 <= addr_in_range ? mem[reqAddr] : '0;
         end
      end
   end

   generate
      if (readLatency == 2) begin : g_lat2
         logic                vld_p1;
         logic [wordSize-1:0] rd_data_p1;

         // Stage p1: extra register stage; data only moves with a valid.
         always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
               vld_p1     <= 1'b0;
               rd_data_p1 <= '0;
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) begin
                  rd_data_p1 <= rd_data_p0;
               end
            end
         end

         assign rspValid = vld_p1;
         assign rspData  = rd_data_p1;
      end else begin : g_lat1
         assign rspValid = vld_p0;
         assign rspData  = rd_data_p0;
      end
   endgenerate

endmodule
